// File: rtl/coin_payout_unit_if.sv
// Payout handshake bundle: vend-controller request, hopper coin handshake,
// refill strobe and stock readback. The payout unit sits on the slave side.
interface coin_payout_unit_if #(
    parameter int STOCK_W = 6
) ();
    logic               pay_valid;
    logic [3:0]         pay_amount;
    logic               pay_ready;
    logic               coin_valid;
    logic [1:0]         coin_code;
    logic               coin_ack;
    logic               pay_done;
    logic               short_fault;
    logic [3:0]         short_amount;
    logic               refill_valid;
    logic [1:0]         refill_code;
    logic [STOCK_W-1:0] stock1;
    logic [STOCK_W-1:0] stock2;
    logic [STOCK_W-1:0] stock3;

    modport master (
        output pay_valid, pay_amount, coin_ack, refill_valid, refill_code,
        input  pay_ready, coin_valid, coin_code, pay_done, short_fault,
               short_amount, stock1, stock2, stock3
    );

    modport slave (
        input  pay_valid, pay_amount, coin_ack, refill_valid, refill_code,
        output pay_ready, coin_valid, coin_code, pay_done, short_fault,
               short_amount, stock1, stock2, stock3
    );
endinterface

// File: rtl/coin_payout_unit.sv
// Greedy coin payout with per-denomination stock, hopper ack handshake and shortfall report.
// Optional audit counters (total_paid, short_count) exist only when PAYOUT_AUDIT_EN is defined.
module coin_payout_unit #(
    parameter int STOCK_W    = 6,
    parameter int INIT_STOCK = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    coin_payout_unit_if.slave  bus
`ifdef PAYOUT_AUDIT_EN
    ,
    output logic [11:0]        total_paid,
    output logic [7:0]         short_count
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        EMIT,
        GAP,
        DONE,
        SHORT
    } state_t;

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0]      GAP_LAST   = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
    localparam logic [STOCK_W-1:0] STOCK_MAX  = '1;
    localparam logic [STOCK_W-1:0] STOCK_INIT = STOCK_W'(INIT_STOCK);

    state_t             state_reg, state_next;
    logic [3:0]         remaining_reg, remaining_next;
    logic               coin_valid_reg, coin_valid_next;
    logic [1:0]         coin_code_reg, coin_code_next;
    logic [3:0]         short_amount_reg, short_amount_next;
    logic [GW-1:0]      gap_cnt_reg, gap_cnt_next;
    logic [STOCK_W-1:0] stock_reg [3];
    logic [STOCK_W-1:0] stock_next [3];
    logic               ack;

    assign ack = (state_reg == EMIT) && bus.coin_ack;

    // Index 0/1/2 holds the 1/2/3-unit coins; a refill and a payout of the same
    // denomination on one edge cancel out.
    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_stock
        logic inc;
        logic dec;
        assign inc = bus.refill_valid && (bus.refill_code == 2'(gi + 1));
        assign dec = ack && (coin_code_reg == 2'(gi + 1));
        assign stock_next[gi] =
            (inc && !dec && (stock_reg[gi] != STOCK_MAX)) ? stock_reg[gi] + STOCK_W'(1) :
            (dec && !inc && (stock_reg[gi] != '0))        ? stock_reg[gi] - STOCK_W'(1) :
                                                             stock_reg[gi];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            remaining_reg    <= '0;
            coin_valid_reg   <= 1'b0;
            coin_code_reg    <= 2'b00;
            short_amount_reg <= '0;
            gap_cnt_reg      <= '0;
            for (int i = 0; i < 3; i++) begin
                stock_reg[i] <= STOCK_INIT;
            end
        end else begin
            state_reg        <= state_next;
            remaining_reg    <= remaining_next;
            coin_valid_reg   <= coin_valid_next;
            coin_code_reg    <= coin_code_next;
            short_amount_reg <= short_amount_next;
            gap_cnt_reg      <= gap_cnt_next;
            for (int i = 0; i < 3; i++) begin
                stock_reg[i] <= stock_next[i];
            end
        end
    end

    always_comb begin
        state_next        = state_reg;
        remaining_next    = remaining_reg;
        coin_valid_next   = coin_valid_reg;
        coin_code_next    = coin_code_reg;
        short_amount_next = short_amount_reg;
        gap_cnt_next      = gap_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (bus.pay_valid) begin
                    remaining_next    = bus.pay_amount;
                    short_amount_next = '0;
                    state_next        = SELECT;
                end
            end
            SELECT: begin
                // Greedy choice against the registered stock; same-cycle refills show up next time.
                if (remaining_reg == 4'd0) begin
                    state_next = DONE;
                end else if ((remaining_reg >= 4'd3) && (stock_reg[2] != '0)) begin
                    coin_code_next  = 2'b11;
                    coin_valid_next = 1'b1;
                    state_next      = EMIT;
                end else if ((remaining_reg >= 4'd2) && (stock_reg[1] != '0)) begin
                    coin_code_next  = 2'b10;
                    coin_valid_next = 1'b1;
                    state_next      = EMIT;
                end else if (stock_reg[0] != '0) begin
                    coin_code_next  = 2'b01;
                    coin_valid_next = 1'b1;
                    state_next      = EMIT;
                end else begin
                    short_amount_next = remaining_reg;
                    state_next        = SHORT;
                end
            end
            EMIT: begin
                if (bus.coin_ack) begin
                    remaining_next  = remaining_reg - {2'b00, coin_code_reg};
                    coin_valid_next = 1'b0;
                    gap_cnt_next    = '0;
                    state_next      = (GAP_CYCLES > 0) ? GAP : SELECT;
                end
            end
            GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next = SELECT;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GW'(1);
                end
            end
            DONE:    state_next = IDLE;
            SHORT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.pay_ready    = (state_reg == IDLE);
    assign bus.coin_valid   = coin_valid_reg;
    assign bus.coin_code    = coin_code_reg;
    assign bus.pay_done     = (state_reg == DONE);
    assign bus.short_fault  = (state_reg == SHORT);
    assign bus.short_amount = short_amount_reg;
    assign bus.stock1       = stock_reg[0];
    assign bus.stock2       = stock_reg[1];
    assign bus.stock3       = stock_reg[2];

`ifdef PAYOUT_AUDIT_EN
    logic [11:0] total_paid_reg;
    logic [7:0]  short_count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total_paid_reg  <= '0;
            short_count_reg <= '0;
        end else begin
            if (ack) begin
                total_paid_reg <= total_paid_reg + {10'b0, coin_code_reg};
            end
            if ((state_reg == SHORT) && (short_count_reg != 8'hFF)) begin
                short_count_reg <= short_count_reg + 8'd1;
            end
        end
    end

    assign total_paid  = total_paid_reg;
    assign short_count = short_count_reg;
`endif

endmodule
